lzc_rr_arbiter: RTL

LZC_RR_ARBITER -- requirements
Module: lzc_rr_arbiter

---
 rtl/lzc_rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/lzc_rr_arbiter.sv
// Round-robin arbiter. The winner is the trailing-zero count of the requests above the last grant.
// The winning payload is captured into a single valid/ready output register.
// Defining LZC_RR_ARBITER_STATS_EN adds a saturating transfer counter on gnt_cnt_o.
module lzc_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [IDX_W-1:0]              idx_o
`ifdef LZC_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]                   gnt_cnt_o
`endif
);

  // Handshake: the input side sees gnt_o as its ready, and a transfer is req_i[i] & gnt_o[i].
  // The output side moves a payload when valid_o & ready_i. The output register reloads
  // in the same cycle it drains, so back-to-back transfers run with no bubble.

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [NUM_REQ-1:0]    masked_req;
  logic [IDX_W-1:0]      winner;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  load;

  function automatic logic [IDX_W-1:0] tzc(input logic [NUM_REQ-1:0] v);
    tzc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) tzc = IDX_W'(i);
    end
  endfunction

  always_comb begin
    masked_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked_req[i] = req_i[i] && (i > int'(ptr_q));
    end
    winner = (|masked_req) ? tzc(masked_req) : tzc(req_i);

    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == winner) win_data = data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Reset suppresses grants so nothing is consumed while the state is being cleared.
    load = (|req_i) && (!valid_q || ready_i) && !rst_i;

    gnt_o         = '0;
    gnt_o[winner] = load;
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (load) begin
      ptr_d   = winner;
      valid_d = 1'b1;
      data_d  = win_data;
      idx_d   = winner;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

`ifdef LZC_RR_ARBITER_STATS_EN
  logic [15:0] gnt_cnt_q, gnt_cnt_d;

  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if (load && (gnt_cnt_q != 16'hFFFF)) gnt_cnt_d = gnt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) gnt_cnt_q <= '0;
    else       gnt_cnt_q <= gnt_cnt_d;
  end

  assign gnt_cnt_o = gnt_cnt_q;
`endif

endmodule
